// File: rtl/if_pkg.sv
// Shared types and defaults for the instruction-fetch stage.
package if_pkg;

    localparam int DEF_WORD_LEN  = 32;
    localparam int DEF_DEPTH     = 4;
    localparam int DEF_MAX_OUTST = 2;
    localparam int unsigned PC_INCR = 32'd4;

    localparam int CNT_W = $clog2(DEF_DEPTH + 1);
    localparam int OUT_W = $clog2(DEF_MAX_OUTST + 1);

    typedef struct packed {
        logic [DEF_WORD_LEN-1:0] pc;
        logic [DEF_WORD_LEN-1:0] instr;
    } fq_entry_t;

endpackage

// File: rtl/if_fetch_queue.sv
// Fetch queue: DEPTH-entry synchronous FIFO with flush and a registered head entry.
module if_fetch_queue
    import if_pkg::*;
#(
    parameter int  DEPTH   = DEF_DEPTH,
    parameter type entry_t = fq_entry_t
) (
    input  logic                         i_clk,
    input  logic                         i_rst,
    input  logic                         i_push,
    input  entry_t                       i_push_data,
    input  logic                         i_pop,
    input  logic                         i_flush,
    output logic                         o_valid,
    output entry_t                       o_head,
    output logic [$clog2(DEPTH+1)-1:0]   o_count_nxt
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W_L = $clog2(DEPTH + 1);

    entry_t               r_mem [DEPTH];
    logic [PTR_W-1:0]     r_wr_ptr;
    logic [PTR_W-1:0]     r_rd_ptr;
    logic [CNT_W_L-1:0]   r_count;
    logic                 r_head_valid;
    entry_t               r_head;

    logic [PTR_W-1:0]     w_rd_ptr_nxt;
    logic [CNT_W_L-1:0]   w_count_nxt;
    logic                 w_pop;
    logic                 w_push;
    entry_t               w_head_nxt;

    // Next pointer/count and the entry that becomes head after this edge
    always_comb begin
        w_pop        = i_pop & r_head_valid;
        w_push       = i_push & ~i_flush & ((r_count != CNT_W_L'(DEPTH)) | w_pop);
        w_rd_ptr_nxt = w_pop ? (r_rd_ptr + PTR_W'(1)) : r_rd_ptr;
        if (i_flush) begin
            w_count_nxt = {CNT_W_L{1'b0}};
        end else begin
            w_count_nxt = r_count + CNT_W_L'(w_push) - CNT_W_L'(w_pop);
        end
        // an entry written this edge can become head immediately (bypass)
        if (w_count_nxt == {CNT_W_L{1'b0}}) begin
            w_head_nxt = {$bits(entry_t){1'b0}};
        end else if (w_push && (w_rd_ptr_nxt == r_wr_ptr)) begin
            w_head_nxt = i_push_data;
        end else begin
            w_head_nxt = r_mem[w_rd_ptr_nxt];
        end
    end

    // Entry storage
    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_push_data;
        end
    end

    // Pointers, occupancy and registered head
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_wr_ptr     <= {PTR_W{1'b0}};
            r_rd_ptr     <= {PTR_W{1'b0}};
            r_count      <= {CNT_W_L{1'b0}};
            r_head_valid <= 1'b0;
            r_head       <= {$bits(entry_t){1'b0}};
        end else if (i_flush) begin
            r_wr_ptr     <= {PTR_W{1'b0}};
            r_rd_ptr     <= {PTR_W{1'b0}};
            r_count      <= {CNT_W_L{1'b0}};
            r_head_valid <= 1'b0;
            r_head       <= {$bits(entry_t){1'b0}};
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            r_rd_ptr     <= w_rd_ptr_nxt;
            r_count      <= w_count_nxt;
            r_head_valid <= (w_count_nxt != {CNT_W_L{1'b0}});
            r_head       <= w_head_nxt;
        end
    end

    assign o_valid     = r_head_valid;
    assign o_head      = r_head;
    assign o_count_nxt = w_count_nxt;

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: PC-sequential req/gnt/rvalid fetch, redirect with in-flight drop, freeze.
// Optional misaligned-target trap is enabled by defining IF_MISALIGN_TRAP_EN.
module if_fetch_unit
    import if_pkg::*;
#(
    parameter int                  WORD_LEN     = DEF_WORD_LEN,
    parameter int                  DEPTH        = DEF_DEPTH,
    parameter int                  MAX_OUTST    = DEF_MAX_OUTST,
    parameter logic [WORD_LEN-1:0] RESET_VECTOR = {WORD_LEN{1'b0}},
    parameter int                  OFFSET_SHIFT = 2
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_branch_taken,
    input  logic [WORD_LEN-1:0] i_branch_pc,
    input  logic [WORD_LEN-1:0] i_branch_offset,
    input  logic                i_freeze,
    output logic                o_imem_req,
    output logic [WORD_LEN-1:0] o_imem_addr,
    input  logic                i_imem_gnt,
    input  logic                i_imem_rvalid,
    input  logic [WORD_LEN-1:0] i_imem_rdata,
    output logic                o_instr_valid,
    output logic [WORD_LEN-1:0] o_pc,
    output logic [WORD_LEN-1:0] o_instruction,
    output logic                o_misalign
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int OW = $clog2(MAX_OUTST + 1);
    localparam logic [WORD_LEN-1:0] INCR = WORD_LEN'(PC_INCR);

    typedef struct packed {
        logic [WORD_LEN-1:0] pc;
        logic [WORD_LEN-1:0] instr;
    } fq_word_entry_t;

    logic [WORD_LEN-1:0] r_fetch_pc, r_addr, r_resp_pc;
    logic                r_req, r_stale, r_misalign;
    logic [OW-1:0]       r_outst, r_discard;

    logic [WORD_LEN-1:0] w_target_raw, w_target, w_fetch_pc_nxt, w_resp_pc_nxt, w_addr_nxt;
    logic                w_tgt_mis, w_gnt, w_drop, w_push, w_pop, w_hold, w_credit;
    logic                w_req_nxt, w_stale_nxt, w_misalign_nxt;
    logic [OW-1:0]       w_outst_nxt, w_discard_nxt;
    logic [CW-1:0]       w_fq_cnt_nxt;
    fq_word_entry_t      w_push_entry, w_head;

    assign w_target_raw = i_branch_pc + (i_branch_offset << OFFSET_SHIFT);
`ifdef IF_MISALIGN_TRAP_EN
    assign w_target  = w_target_raw;
    assign w_tgt_mis = (w_target_raw[1:0] != 2'b00);
`else
    assign w_target  = w_target_raw & {{(WORD_LEN-2){1'b1}}, 2'b00};
    assign w_tgt_mis = 1'b0;
`endif

    // Handshake events and credit check against post-edge occupancy
    always_comb begin
        w_gnt        = r_req & i_imem_gnt;
        w_hold       = r_req & ~i_imem_gnt;
        w_drop       = i_imem_rvalid & (r_discard != {OW{1'b0}});
        w_push       = i_imem_rvalid & ~w_drop & ~i_branch_taken;
        w_pop        = o_instr_valid & ~i_freeze;
        w_outst_nxt  = r_outst + OW'(w_gnt) - OW'(i_imem_rvalid);
        w_credit     = ((32'(w_outst_nxt) + 32'(w_fq_cnt_nxt)) < 32'(DEPTH)) &&
                       (32'(w_outst_nxt) < 32'(MAX_OUTST));
        w_push_entry = '{pc: r_resp_pc, instr: i_imem_rdata};
    end

    // Next PC, tracker, discard accounting and request issue
    always_comb begin
        if (i_branch_taken) begin
            // everything still in flight after this edge belongs to the old path
            w_fetch_pc_nxt = w_target;
            w_resp_pc_nxt  = w_target;
            w_discard_nxt  = w_outst_nxt;
            w_stale_nxt    = w_hold;
            w_misalign_nxt = w_tgt_mis;
        end else begin
            w_fetch_pc_nxt = (w_gnt && !r_stale) ? (r_fetch_pc + INCR) : r_fetch_pc;
            w_resp_pc_nxt  = w_push ? (r_resp_pc + INCR) : r_resp_pc;
            // a stale request granted late still returns data that must be dropped
            w_discard_nxt  = r_discard - OW'(w_drop) + OW'(w_gnt & r_stale);
            w_stale_nxt    = r_stale & ~w_gnt;
            w_misalign_nxt = r_misalign;
        end
        if (w_hold) begin
            w_req_nxt  = 1'b1;
            w_addr_nxt = r_addr;
        end else begin
            w_req_nxt  = w_credit & ~i_branch_taken & ~w_misalign_nxt;
            w_addr_nxt = w_fetch_pc_nxt;
        end
    end

    // Fetch state registers
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_fetch_pc <= RESET_VECTOR;
            r_addr     <= RESET_VECTOR;
            r_resp_pc  <= RESET_VECTOR;
            r_req      <= 1'b0;
            r_stale    <= 1'b0;
            r_misalign <= 1'b0;
            r_outst    <= {OW{1'b0}};
            r_discard  <= {OW{1'b0}};
        end else begin
            r_fetch_pc <= w_fetch_pc_nxt;
            r_addr     <= w_addr_nxt;
            r_resp_pc  <= w_resp_pc_nxt;
            r_req      <= w_req_nxt;
            r_stale    <= w_stale_nxt;
            r_misalign <= w_misalign_nxt;
            r_outst    <= w_outst_nxt;
            r_discard  <= w_discard_nxt;
        end
    end

    if_fetch_queue #(
        .DEPTH   (DEPTH),
        .entry_t (fq_word_entry_t)
    ) u_fq (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_push      (w_push),
        .i_push_data (w_push_entry),
        .i_pop       (w_pop),
        .i_flush     (i_branch_taken),
        .o_valid     (o_instr_valid),
        .o_head      (w_head),
        .o_count_nxt (w_fq_cnt_nxt)
    );

    assign o_imem_req    = r_req;
    assign o_imem_addr   = r_addr;
    assign o_pc          = w_head.pc;
    assign o_instruction = w_head.instr;
    assign o_misalign    = r_misalign;

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed self-checking bench for if_fetch_unit with a simple in-order instruction memory model.
module tb_if_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        br;
    logic [31:0] bpc, boff;
    logic        freeze;
    logic        imem_req, imem_rvalid, instr_valid, misalign;
    logic [31:0] imem_addr, imem_rdata, pc, instr;
    logic        gnt_en, rsp_en;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct { logic [31:0] pc; logic [31:0] ins; int cyc; } log_t;
    log_t        log_q[$];
    logic [31:0] pend_q[$];
    logic [31:0] held;
    int          nlog;

    if_fetch_unit dut (
        .i_clk(clk), .i_rst(rst), .i_branch_taken(br), .i_branch_pc(bpc),
        .i_branch_offset(boff), .i_freeze(freeze), .o_imem_req(imem_req),
        .o_imem_addr(imem_addr), .i_imem_gnt(gnt_en), .i_imem_rvalid(imem_rvalid),
        .i_imem_rdata(imem_rdata), .o_instr_valid(instr_valid), .o_pc(pc),
        .o_instruction(instr), .o_misalign(misalign)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_f(input logic [31:0] a);
        return a ^ 32'h1357_9BDF;
    endfunction

    function automatic logic [31:0] lpc(input int i);
        return (i < log_q.size()) ? log_q[i].pc : 32'hDEAD_DEAD;
    endfunction

    function automatic logic [31:0] lins(input int i);
        return (i < log_q.size()) ? log_q[i].ins : 32'hDEAD_DEAD;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // memory: accept on grant, answer in order one cycle later
    always @(posedge clk) begin
        if (rst) pend_q.delete();
        else if (imem_req && gnt_en) pend_q.push_back(imem_addr);
    end

    always @(negedge clk) begin
        if (!rst && rsp_en && pend_q.size() > 0) begin
            imem_rvalid = 1'b1;
            imem_rdata  = mem_f(pend_q.pop_front());
        end else begin
            imem_rvalid = 1'b0;
            imem_rdata  = 32'd0;
        end
    end

    // consumer side: record every instruction handed to ID
    always @(posedge clk) begin
        if (!rst && instr_valid && !freeze)
            log_q.push_back('{pc, instr, int'($time / 10)});
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; br = 1'b0; bpc = 32'd0; boff = 32'd0; freeze = 1'b0;
        gnt_en = 1'b1; rsp_en = 1'b1;
        repeat (2) tick();
        chk("rst_req",   32'(imem_req),    32'd0);
        chk("rst_valid", 32'(instr_valid), 32'd0);
        chk("rst_pc",    pc,               32'd0);
        chk("rst_instr", instr,            32'd0);
        chk("rst_mis",   32'(misalign),    32'd0);
        chk("rst_addr",  imem_addr,        32'd0);

        // 1: streaming fetch, one instruction per cycle
        rst = 1'b0;
        repeat (12) tick();
        chk("t1_count", 32'(log_q.size() >= 6), 32'd1);
        for (int i = 0; i < 6; i++) begin
            chk("t1_pc",  lpc(i),  32'(4 * i));
            chk("t1_ins", lins(i), mem_f(32'(4 * i)));
            chk("t1_cyc", 32'((i < log_q.size()) ? log_q[i].cyc - log_q[0].cyc : -1), 32'(i));
        end

        // 2: freeze holds head and throttles requests; no loss or duplication on release
        freeze = 1'b1;
        held = pc;
        nlog = log_q.size();
        chk("t2_head", held, 32'(4 * nlog));
        repeat (10) tick();
        chk("t2_req",   32'(imem_req),     32'd0);
        chk("t2_valid", 32'(instr_valid),  32'd1);
        chk("t2_pc",    pc,                held);
        chk("t2_ins",   instr,             mem_f(held));
        chk("t2_nopop", 32'(log_q.size()), 32'(nlog));
        freeze = 1'b0;
        repeat (10) tick();
        chk("t2_prog", 32'(log_q.size() >= nlog + 8), 32'd1);
        for (int i = 0; i < log_q.size(); i++) begin
            chk("t2_seq_pc",  lpc(i),  32'(4 * i));
            chk("t2_seq_ins", lins(i), mem_f(32'(4 * i)));
        end

        // 3: redirect with two requests outstanding
        rsp_en = 1'b0;
        repeat (4) tick();
        chk("t3_cap_req", 32'(imem_req), 32'd0);
        br = 1'b1; bpc = 32'h20; boff = 32'd3;
        tick();
        br = 1'b0; rsp_en = 1'b1;
        log_q.delete();
        chk("t3_valid", 32'(instr_valid), 32'd0);
        chk("t3_req",   32'(imem_req),    32'd0);
        repeat (12) tick();
        chk("t3_pc0",  lpc(0),  32'h2C);
        chk("t3_ins0", lins(0), mem_f(32'h2C));
        chk("t3_pc1",  lpc(1),  32'h30);

        // 4: grant stall keeps the request stable; redirect while it waits
        gnt_en = 1'b0;
        held = imem_addr;
        repeat (5) tick();
        chk("t4_req",  32'(imem_req), 32'd1);
        chk("t4_addr", imem_addr,     held);
        br = 1'b1; bpc = 32'h40; boff = 32'd4;
        tick();
        br = 1'b0;
        log_q.delete();
        chk("t4_hold_req",  32'(imem_req), 32'd1);
        chk("t4_hold_addr", imem_addr,     held);
        gnt_en = 1'b1;
        repeat (10) tick();
        chk("t4_pc0",  lpc(0),  32'h50);
        chk("t4_ins0", lins(0), mem_f(32'h50));
        chk("t4_pc1",  lpc(1),  32'h54);

        // 5: address wrap, then reset in the middle of a burst
        br = 1'b1; bpc = 32'hFFFF_FFF0; boff = 32'd3;
        tick();
        br = 1'b0;
        log_q.delete();
        repeat (8) tick();
        chk("t5_pc0",  lpc(0),  32'hFFFF_FFFC);
        chk("t5_pc1",  lpc(1),  32'h0000_0000);
        chk("t5_ins1", lins(1), mem_f(32'h0));
        chk("t5_pc2",  lpc(2),  32'h0000_0004);
        rst = 1'b1;
        #1;
        chk("t5_rst_req",   32'(imem_req),    32'd0);
        chk("t5_rst_valid", 32'(instr_valid), 32'd0);
        chk("t5_rst_pc",    pc,               32'd0);
        chk("t5_rst_instr", instr,            32'd0);
        chk("t5_rst_addr",  imem_addr,        32'd0);
        repeat (2) tick();
        rst = 1'b0;
        log_q.delete();
        repeat (8) tick();
        chk("t5_re_pc0", lpc(0), 32'h0);
        chk("t5_re_pc1", lpc(1), 32'h4);

        // 6: misaligned redirect target
        br = 1'b1; bpc = 32'h102; boff = 32'd0;
        tick();
        br = 1'b0;
        log_q.delete();
`ifdef IF_MISALIGN_TRAP_EN
        chk("t6_mis_set", 32'(misalign), 32'd1);
        repeat (6) tick();
        chk("t6_mis_hold", 32'(misalign),    32'd1);
        chk("t6_req",      32'(imem_req),    32'd0);
        chk("t6_valid",    32'(instr_valid), 32'd0);
        chk("t6_nolog",    32'(log_q.size()), 32'd0);
        br = 1'b1; bpc = 32'h200; boff = 32'd0;
        tick();
        br = 1'b0;
        log_q.delete();
        chk("t6_mis_clr", 32'(misalign), 32'd0);
        repeat (8) tick();
        chk("t6_pc0", lpc(0), 32'h200);
        chk("t6_pc1", lpc(1), 32'h204);
`else
        chk("t6_mis", 32'(misalign), 32'd0);
        repeat (8) tick();
        chk("t6_mis_hold", 32'(misalign), 32'd0);
        chk("t6_pc0",  lpc(0),  32'h100);
        chk("t6_ins0", lins(0), mem_f(32'h100));
        chk("t6_pc1",  lpc(1),  32'h104);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
